// File: rtl/pwm_duty_capture.sv
// Recovers the duty (high clocks per frame) of one asynchronous PWM line whose
// frame length is fixed at 2^CNT_W clocks; flags bad frame lengths and dead lines.
module pwm_duty_capture #(
  parameter int CNT_W  = 8,
  parameter int TO_MUL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] duty,
  output logic             duty_vld,
  output logic             per_err,
  output logic             stuck
);

  localparam int PW = CNT_W + 2;
  localparam int HW = CNT_W + 1;
  localparam logic [PW-1:0] FRAME_LEN = PW'(2 ** CNT_W);
  localparam logic [PW-1:0] TO_LEN    = PW'(TO_MUL * (2 ** CNT_W));

  typedef enum logic [1:0] {IDLE, MEAS, STUCK} state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_s;
  logic          r_sd;
  logic [PW-1:0] r_per_cnt;
  logic [HW-1:0] r_hi_cnt;
  logic          w_rise;
  logic          w_timeout;

  assign w_rise    = r_s & ~r_sd;
  assign w_timeout = (r_per_cnt == TO_LEN) && !w_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_s     <= 1'b0;
      r_sd    <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_s     <= r_sync1;
      r_sd    <= r_s;
    end
  end

  // Both counters saturate so a dead line can never wrap into a fake frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
    end else if (w_rise) begin
      r_per_cnt <= PW'(1);
      r_hi_cnt  <= HW'(1);
    end else begin
      if (r_per_cnt != '1)
        r_per_cnt <= r_per_cnt + PW'(1);
      if (r_s && (r_hi_cnt != '1))
        r_hi_cnt <= r_hi_cnt + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      duty     <= '0;
      duty_vld <= 1'b0;
      per_err  <= 1'b0;
      stuck    <= 1'b0;
    end else begin
      duty_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= MEAS;
          end else if (w_timeout) begin
            r_state  <= STUCK;
            duty     <= {CNT_W{r_s}};
            duty_vld <= 1'b1;
            stuck    <= 1'b1;
          end
        end
        MEAS: begin
          if (w_rise) begin
            // A frame of the wrong length only raises the error; duty is kept.
            if (r_per_cnt == FRAME_LEN) begin
              duty     <= r_hi_cnt[CNT_W-1:0];
              duty_vld <= 1'b1;
              per_err  <= 1'b0;
              stuck    <= 1'b0;
            end else begin
              per_err <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state  <= STUCK;
            duty     <= {CNT_W{r_s}};
            duty_vld <= 1'b1;
            stuck    <= 1'b1;
          end
        end
        STUCK: begin
          if (w_rise)
            r_state <= MEAS;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Randomized PWM frames checked against a frame-level model of the duty capture:
// each pin rise closes a frame whose length and high count predict the next report.
module tb_pwm_duty_capture;

  localparam int CNT_W = 8;
  localparam int FRAME = 256;
  localparam int TO    = 512;
  localparam int LAT   = 3;
  localparam int WIN   = 4;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] duty;
  logic             duty_vld;
  logic             per_err;
  logic             stuck;

  pwm_duty_capture #(.CNT_W(CNT_W), .TO_MUL(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwm_in   (pwm_in),
    .duty     (duty),
    .duty_vld (duty_vld),
    .per_err  (per_err),
    .stuck    (stuck)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int duty;
    int stk;
    int perr;
    int t;
  } expEv_t;

  expEv_t expQ[$];

  // Frame-level model state: where the current frame started and what it holds.
  bit prevP;
  bit mMeas;
  bit mTimedOut;
  bit mPerErr;
  bit mStuck;
  int lastRise;
  int hiCnt;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cycle);
    end
  endtask

  task automatic modelReset();
    expQ.delete();
    prevP     = 1'b0;
    mMeas     = 1'b0;
    mTimedOut = 1'b0;
    mPerErr   = 1'b0;
    mStuck    = 1'b0;
    hiCnt     = 0;
    lastRise  = cycle;
  endtask

  // Drive one clock of pin level and advance the model by one clock.
  task automatic applyStimulus(input bit p);
    expEv_t ev;
    @(posedge clk);
    #1;
    pwm_in = p;
    if (p && !prevP) begin
      if (mMeas) begin
        if (cycle - lastRise == FRAME) begin
          ev.duty = hiCnt;
          ev.stk  = 0;
          ev.perr = 0;
          ev.t    = cycle + LAT;
          expQ.push_back(ev);
          mPerErr = 1'b0;
          mStuck  = 1'b0;
        end else begin
          mPerErr = 1'b1;
        end
      end
      mMeas     = 1'b1;
      mTimedOut = 1'b0;
      lastRise  = cycle;
      hiCnt     = 0;
    end else if (!mTimedOut && (cycle - lastRise == TO)) begin
      ev.duty = p ? 255 : 0;
      ev.stk  = 1;
      ev.perr = mPerErr;
      ev.t    = cycle + LAT;
      expQ.push_back(ev);
      mMeas     = 1'b0;
      mTimedOut = 1'b1;
      mStuck    = 1'b1;
    end
    if (p) hiCnt++;
    prevP = p;
  endtask

  task automatic driveFrame(input int high, input int period);
    for (int i = 0; i < period; i++) applyStimulus(i < high);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_per_err"}, per_err, mPerErr);
    checkOutput({tag, "_stuck"}, stuck, mStuck);
  endtask

  // Every report must match the oldest outstanding prediction within a few clocks.
  always @(negedge clk) begin
    expEv_t ev;
    if (rst_n) begin
      if (duty_vld) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_vld", 1, 0);
        end else begin
          ev = expQ.pop_front();
          checkOutput("duty", duty, ev.duty);
          checkOutput("stuck_at_vld", stuck, ev.stk);
          checkOutput("per_err_at_vld", per_err, ev.perr);
          checkOutput("vld_window", (cycle + WIN >= ev.t) && (cycle <= ev.t + WIN), 1);
        end
      end else if (expQ.size() != 0 && cycle > expQ[0].t + WIN) begin
        checkOutput("missing_vld", 0, 1);
        void'(expQ.pop_front());
      end
    end
  end

  initial begin
    int hi;
    int per;
    modelReset();
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_duty", duty, 0);
    checkOutput("rst_vld", duty_vld, 0);
    checkOutput("rst_per_err", per_err, 0);
    checkOutput("rst_stuck", stuck, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();

    $display("[TB] steady duty 0x40 then step to 0xC0");
    repeat (5) driveFrame(8'h40, FRAME);
    repeat (3) driveFrame(8'hC0, FRAME);
    checkQuiet("step");

    $display("[TB] random frames with occasional bad periods");
    for (int n = 0; n < 12; n++) begin
      per = ($urandom_range(0, 3) == 0) ? $urandom_range(200, 255) : FRAME;
      hi  = $urandom_range(1, per - 1);
      driveFrame(hi, per);
      checkQuiet("rand");
    end
    repeat (2) driveFrame($urandom_range(1, 254), FRAME);

    $display("[TB] short period 250 then recovery");
    repeat (3) driveFrame(100, 250);
    checkQuiet("short");
    repeat (3) driveFrame(8'h40, FRAME);
    checkQuiet("recover");

    $display("[TB] runt pulse inside a frame");
    driveFrame(8'h40, 100);
    driveFrame(1, 3);
    driveFrame(8'h40, 153);
    checkQuiet("runt");
    repeat (3) driveFrame(8'h40, FRAME);

    $display("[TB] line held low, then duty 0x80");
    driveFrame(0, 600);
    checkQuiet("hold_lo");
    checkOutput("hold_lo_duty", duty, 0);
    repeat (3) driveFrame(8'h80, FRAME);
    checkQuiet("after_lo");

    $display("[TB] line held high, then duty 0xFF");
    driveFrame(600, 600);
    checkQuiet("hold_hi");
    checkOutput("hold_hi_duty", duty, 8'hFF);
    repeat (4) driveFrame(255, FRAME);
    checkQuiet("full");

    $display("[TB] reset in the middle of a frame");
    driveFrame(100, 250);
    driveFrame(40, 40);
    checkOutput("pre_rst_per_err", per_err, 1);
    checkOutput("pre_rst_duty", duty, 8'hFF);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_duty", duty, 0);
    checkOutput("async_rst_vld", duty_vld, 0);
    checkOutput("async_rst_per_err", per_err, 0);
    checkOutput("async_rst_stuck", stuck, 0);
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    driveFrame(80, 100);
    repeat (4) driveFrame(8'h80, FRAME);
    applyStimulus(1'b1);
    repeat (10) applyStimulus(1'b0);
    checkQuiet("post_rst");

    repeat (20) @(posedge clk);
    checkOutput("leftover_events", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
